tb_campaign_sequencer: RTL and testbench
========================================

# tb_campaign_sequencer

Sequencer for the arithmetic testbench. It runs a campaign of up to `NUM_CFG` fault configurations back to back. For each configuration it resets the testbench, applies the fault and manual-operand settings, runs until a programmed number of data items has been counted, then freezes and records the event count. It sits above the testbench instance, drives its reset/enable/freeze and fault-control inputs, and reads back its data and event counters.

## Interface
- `WIDTH`, 16: operand width; matches the testbench.
- `NUM_CFG`, 8: configuration/result table depth, power of two. `IDXW = log2(NUM_CFG)`.
- `RST_CYCLES`, 4: cycles testbench reset is held per configuration (≥1).
- `SETTLE_CYCLES`, 8: cycles with settings applied and enable low before a run (≥1).

Ports:
- `clk_dut` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `i_start` in 1: level; sampled only in IDLE.
- `i_abort` in 1: level; ends the campaign from any state.
- `i_num_samples` in 32: data items per configuration; latched at start.
- `i_num_cfg` in IDXW+1: number of configurations to run (0..NUM_CFG); latched at start.
- `i_cfg_we` in 1: table write strobe; ignored while busy.
- `i_cfg_idx` in IDXW: table entry index.
- `i_cfg_field` in 3: 0 manual_a, 1 manual_b, 2 bitset_a, 3 bitset_b, 4 bitclr_a, 5 bitclr_b, 6 fselect (uses data bit 0), 7 ignored.
- `i_cfg_data` in WIDTH: write data.
- `i_res_idx` in IDXW: result read index.
- `o_res_event_ctr` out 32: result table entry at `i_res_idx`; combinational read.
- `i_data_ctr` in 32: from the testbench `o_data_ctr`.
- `i_event_ctr` in 32: from the testbench `o_event_ctr`.
- `o_tb_reset` out 1: testbench reset, active-high.
- `o_tb_enable` out 1: testbench enable.
- `o_tb_freeze` out 1: testbench freeze.
- `o_fselect` out 1: fault select for the current configuration.
- `o_fmanual_a`, `o_fmanual_b`, `o_fbitset_a`, `o_fbitset_b`, `o_fbitclr_a`, `o_fbitclr_b` out WIDTH each: fault/manual settings for the current configuration.
- `o_cur_cfg` out IDXW: index of the configuration being run.
- `o_busy` out 1: high in every state except IDLE and DONE.
- `o_done` out 1: high in DONE.

## Operation
- State machine states: IDLE, CLEAR, SETTLE, RUN, FREEZE, RECORD, DONE.
- **IDLE**: `tb_reset`=0, `enable`=0, `freeze`=1. Table writes are accepted.
  - On `i_start`=1 with `i_num_cfg`≠0: latch the parameters, set `cur_cfg`=0, go to CLEAR.
  - On `i_start`=1 with `i_num_cfg`=0: go to DONE; no result entry is written.
- **CLEAR**: `tb_reset`=1, `enable`=0, `freeze`=1. Load all setting outputs from table entry `cur_cfg`. After RST_CYCLES cycles, go to SETTLE.
- **SETTLE**: `tb_reset`=0, `enable`=0, `freeze`=0. After SETTLE_CYCLES cycles, go to RUN.
- **RUN**: `enable`=1, `freeze`=0. Leave when `i_data_ctr ≥ num_samples` (unsigned compare) and go to FREEZE. With `num_samples`=0, RUN lasts exactly 1 cycle.
- **FREEZE**: `enable`=0, `freeze`=1. Hold for 2 cycles so the counters settle, then go to RECORD.
- **RECORD**: 1 cycle. Write `result[cur_cfg] <= i_event_ctr`.
  - If `cur_cfg+1 == num_cfg`: go to DONE.
  - Otherwise increment `cur_cfg` and go to CLEAR.
- **DONE**: `enable`=0, `freeze`=1, `tb_reset`=0. Counters and settings stay visible. Return to IDLE when `i_start`=0.
- **Abort**: `i_abort`=1 in any busy state goes to IDLE next cycle.
  - The results already recorded are kept.
  - A partial configuration is not recorded.
  - `i_abort` has priority over every other transition. In IDLE and DONE it has no effect, except that DONE goes to IDLE.
- Table writes in a busy state are dropped. Writes to field 7 are dropped.
- Results in the table are not cleared by start; untouched entries keep their old values.
- The table and all registers are fully accessible on the first cycle after reset release.

## Timing
- Reset (`reset`=0, asynchronous) values:
  - state IDLE, `cur_cfg`=0, `o_busy`=0, `o_done`=0.
  - `o_tb_reset`=1, `o_tb_enable`=0, `o_tb_freeze`=1.
  - All setting outputs 0; config table and result table 0.
  - From the first clock after release, IDLE drives `o_tb_reset`=0.
- All control and setting outputs are registered and change on the clock edge that enters the state.
- Start at edge E: CLEAR at E+1, SETTLE at E+1+RST_CYCLES, RUN at E+1+RST_CYCLES+SETTLE_CYCLES.
- Per-configuration overhead outside RUN is RST_CYCLES + SETTLE_CYCLES + 3 cycles.
- `o_done` rises the cycle after the last RECORD.
- Reset asserted mid-campaign: immediate return to the reset values; the result table is cleared.

## Test plan
- Program cfg0 with fselect=1, bitset_a=0x0001; `num_cfg`=1, `num_samples`=100. Pulse start. -> CLEAR exactly 4 cycles with `o_tb_reset`=1 and `o_fbitset_a`=0x0001; SETTLE exactly 8 cycles; `enable` high until `i_data_ctr`≥100; `result[0]`=`i_event_ctr` sampled in RECORD; `o_done`=1.
- `num_cfg`=3 with distinct bitclr_b values 0x8000, 0x4000, 0x0001. -> `o_cur_cfg` steps 0,1,2; outputs match each entry; 3 results written; DONE after the third RECORD.
- `num_samples`=0. -> RUN lasts 1 cycle per configuration; the campaign still completes.
- `num_cfg`=0 with start. -> DONE next cycle; `o_busy` never high; result table unchanged.
- Abort in RUN of cfg1 in a 4-configuration campaign. -> IDLE next cycle; `result[0]` kept, `result[1]` unchanged; `enable`=0, `freeze`=1.
- Table write to cfg2 while busy -> ignored. Async reset in SETTLE -> outputs at reset values within the same cycle; result table reads 0.

Source files
------------

// File: rtl/tb_campaign_sequencer.sv
// Campaign sequencer: runs up to NUM_CFG fault configurations back to back
// against the arithmetic testbench and records one event count per config.
module tb_campaign_sequencer #(
  parameter int WIDTH         = 16,
  parameter int NUM_CFG       = 8,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  localparam int IDXW         = $clog2(NUM_CFG)
) (
  input  logic              clk_dut,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [31:0]       i_num_samples,
  input  logic [IDXW:0]     i_num_cfg,
  input  logic              i_cfg_we,
  input  logic [IDXW-1:0]   i_cfg_idx,
  input  logic [2:0]        i_cfg_field,
  input  logic [WIDTH-1:0]  i_cfg_data,
  input  logic [IDXW-1:0]   i_res_idx,
  output logic [31:0]       o_res_event_ctr,
  input  logic [31:0]       i_data_ctr,
  input  logic [31:0]       i_event_ctr,
  output logic              o_tb_reset,
  output logic              o_tb_enable,
  output logic              o_tb_freeze,
  output logic              o_fselect,
  output logic [WIDTH-1:0]  o_fmanual_a,
  output logic [WIDTH-1:0]  o_fmanual_b,
  output logic [WIDTH-1:0]  o_fbitset_a,
  output logic [WIDTH-1:0]  o_fbitset_b,
  output logic [WIDTH-1:0]  o_fbitclr_a,
  output logic [WIDTH-1:0]  o_fbitclr_b,
  output logic [IDXW-1:0]   o_cur_cfg,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNTW = $clog2(CMAX + 2);
  localparam logic [IDXW:0] ONE_N = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_RUN, S_FREEZE, S_RECORD, S_DONE
  } state_t;

  // one configuration's fault / manual-operand settings
  typedef struct packed {
    logic             fsel;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] bsa;
    logic [WIDTH-1:0] bsb;
    logic [WIDTH-1:0] bca;
    logic [WIDTH-1:0] bcb;
  } cfg_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   cur_q, cur_d;
  logic [31:0]       ns_q, ns_d;
  logic [IDXW:0]     nc_q, nc_d;
  logic              tb_reset_q, tb_reset_d;
  logic              enable_q, enable_d;
  logic              freeze_q, freeze_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  cfg_t              cfg_q, cfg_d;
  logic              rec_we;
  logic              busy_st;

  cfg_t              tbl_q [NUM_CFG];
  logic [31:0]       res_q [NUM_CFG];

  assign busy_st = !(state_q inside {S_IDLE, S_DONE});

  // next-state, phase counter and registered-output decode (outputs follow the state being entered)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    ns_d    = ns_q;
    nc_d    = nc_q;
    rec_we  = 1'b0;
    if (i_abort && busy_st) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          if (i_num_cfg == '0) state_d = S_DONE;
          else begin
            ns_d    = i_num_samples;
            nc_d    = i_num_cfg;
            cur_d   = '0;
            cnt_d   = '0;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: if (cnt_q == CNTW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else cnt_d = cnt_q + CNTW'(1);
        S_SETTLE: if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else cnt_d = cnt_q + CNTW'(1);
        S_RUN: if (i_data_ctr >= ns_q) begin
          cnt_d   = '0;
          state_d = S_FREEZE;
        end
        // two frozen cycles so the counters are stable before sampling
        S_FREEZE: if (cnt_q == CNTW'(1)) begin
          cnt_d   = '0;
          state_d = S_RECORD;
        end else cnt_d = cnt_q + CNTW'(1);
        S_RECORD: begin
          rec_we = 1'b1;
          if (({1'b0, cur_q} + ONE_N) == nc_q) state_d = S_DONE;
          else begin
            cur_d   = cur_q + IDXW'(1);
            cnt_d   = '0;
            state_d = S_CLEAR;
          end
        end
        S_DONE: if (i_abort || !i_start) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    tb_reset_d = (state_d == S_CLEAR);
    enable_d   = (state_d == S_RUN);
    freeze_d   = !(state_d inside {S_SETTLE, S_RUN});
    busy_d     = !(state_d inside {S_IDLE, S_DONE});
    done_d     = (state_d == S_DONE);
    cfg_d      = (state_d == S_CLEAR) ? tbl_q[cur_d] : cfg_q;
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_q      <= '0;
      ns_q       <= '0;
      nc_q       <= '0;
      tb_reset_q <= 1'b1;
      enable_q   <= 1'b0;
      freeze_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      ns_q       <= ns_d;
      nc_q       <= nc_d;
      tb_reset_q <= tb_reset_d;
      enable_q   <= enable_d;
      freeze_q   <= freeze_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_q      <= cfg_d;
    end
  end

  // config table writes (idle/done only) and result capture in RECORD
  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        tbl_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (i_cfg_we && !busy_st) begin
        case (i_cfg_field)
          3'd0: tbl_q[i_cfg_idx].ma   <= i_cfg_data;
          3'd1: tbl_q[i_cfg_idx].mb   <= i_cfg_data;
          3'd2: tbl_q[i_cfg_idx].bsa  <= i_cfg_data;
          3'd3: tbl_q[i_cfg_idx].bsb  <= i_cfg_data;
          3'd4: tbl_q[i_cfg_idx].bca  <= i_cfg_data;
          3'd5: tbl_q[i_cfg_idx].bcb  <= i_cfg_data;
          3'd6: tbl_q[i_cfg_idx].fsel <= i_cfg_data[0];
          default: ;
        endcase
      end
      if (rec_we) res_q[cur_q] <= i_event_ctr;
    end
  end

  assign o_res_event_ctr = res_q[i_res_idx];
  assign o_tb_reset      = tb_reset_q;
  assign o_tb_enable     = enable_q;
  assign o_tb_freeze     = freeze_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_cur_cfg       = cur_q;
  assign o_fselect       = cfg_q.fsel;
  assign o_fmanual_a     = cfg_q.ma;
  assign o_fmanual_b     = cfg_q.mb;
  assign o_fbitset_a     = cfg_q.bsa;
  assign o_fbitset_b     = cfg_q.bsb;
  assign o_fbitclr_a     = cfg_q.bca;
  assign o_fbitclr_b     = cfg_q.bcb;

endmodule

// File: tb/tb_tb_campaign_sequencer.sv
// Bench for tb_campaign_sequencer: a stand-in arithmetic testbench (data
// counter, event counter derived from the settings), a campaign-timeline
// model and a per-cycle compare, plus directed literal checks.
module tb_tb_campaign_sequencer;
  localparam int W = 16, NC = 8, IW = 3, RSTC = 4, SETC = 8;

  logic clk_dut = 1'b0, reset = 1'b0;
  always #5 clk_dut = ~clk_dut;

  logic          i_start = 0, i_abort = 0, i_cfg_we = 0;
  logic [31:0]   i_num_samples = 0;
  logic [IW:0]   i_num_cfg = 0;
  logic [IW-1:0] i_cfg_idx = 0, i_res_idx = 0;
  logic [2:0]    i_cfg_field = 0;
  logic [W-1:0]  i_cfg_data = 0;
  logic [31:0]   i_data_ctr, i_event_ctr, o_res_event_ctr;
  logic          o_tb_reset, o_tb_enable, o_tb_freeze, o_fselect, o_busy, o_done;
  logic [W-1:0]  o_fmanual_a, o_fmanual_b, o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b;
  logic [IW-1:0] o_cur_cfg;

  tb_campaign_sequencer #(.WIDTH(W), .NUM_CFG(NC), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC)) dut (
    .clk_dut(clk_dut), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_num_samples(i_num_samples), .i_num_cfg(i_num_cfg), .i_cfg_we(i_cfg_we),
    .i_cfg_idx(i_cfg_idx), .i_cfg_field(i_cfg_field), .i_cfg_data(i_cfg_data),
    .i_res_idx(i_res_idx), .o_res_event_ctr(o_res_event_ctr), .i_data_ctr(i_data_ctr),
    .i_event_ctr(i_event_ctr), .o_tb_reset(o_tb_reset), .o_tb_enable(o_tb_enable),
    .o_tb_freeze(o_tb_freeze), .o_fselect(o_fselect), .o_fmanual_a(o_fmanual_a),
    .o_fmanual_b(o_fmanual_b), .o_fbitset_a(o_fbitset_a), .o_fbitset_b(o_fbitset_b),
    .o_fbitclr_a(o_fbitclr_a), .o_fbitclr_b(o_fbitclr_b), .o_cur_cfg(o_cur_cfg),
    .o_busy(o_busy), .o_done(o_done));

  // stand-in testbench: counts data while enabled, cleared by its reset
  logic [31:0] data_q;
  always_ff @(posedge clk_dut or negedge reset)
    if (!reset) data_q <= '0;
    else if (o_tb_reset) data_q <= '0;
    else if (o_tb_enable) data_q <= data_q + 32'd1;
  assign i_data_ctr  = data_q;
  assign i_event_ctr = 32'(o_fbitclr_b) + data_q * 32'd3 + 32'(o_fselect);

  int n_vec = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- model: whole-campaign timeline ----------------
  typedef struct packed {
    logic fsel; logic [W-1:0] ma, mb, bsa, bsb, bca, bcb;
  } cfg_t;
  typedef struct packed {
    logic rst, en, fr, busy, done, rec; logic [IW-1:0] cur; cfg_t cfg;
  } exp_t;

  exp_t        mexp;
  exp_t        tl[$];
  cfg_t        mtbl [NC];
  logic [31:0] mres [NC];
  int          mns;

  task automatic model_reset();
    mexp = '0; mexp.rst = 1; mexp.fr = 1;
    tl.delete();
    for (int i = 0; i < NC; i++) begin mtbl[i] = '0; mres[i] = '0; end
  endtask

  task automatic push(input int n, input logic r, input logic e, input logic f,
                      input logic rec, input int c);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x = '0; x.rst = r; x.en = e; x.fr = f; x.busy = 1; x.rec = rec;
      x.cur = IW'(c); x.cfg = mtbl[c];
      tl.push_back(x);
    end
  endtask

  task automatic model_step();
    logic was_busy;
    was_busy = mexp.busy;
    if (was_busy) begin
      if (i_abort) begin
        tl.delete();
        mexp.rst = 0; mexp.en = 0; mexp.fr = 1; mexp.busy = 0; mexp.done = 0; mexp.rec = 0;
      end else begin
        if (mexp.rec) mres[mexp.cur] = 32'(mexp.cfg.bcb) + 32'(3 * (mns + 1)) + 32'(mexp.cfg.fsel);
        if (tl.size() > 0) mexp = tl.pop_front();
        else begin mexp.en = 0; mexp.fr = 1; mexp.busy = 0; mexp.done = 1; mexp.rec = 0; end
      end
    end else if (mexp.done) begin
      if (!i_start || i_abort) mexp.done = 0;
    end else begin
      mexp.rst = 0; mexp.en = 0; mexp.fr = 1;
      if (i_start) begin
        if (i_num_cfg == 0) mexp.done = 1;
        else begin
          mns = int'(i_num_samples);
          for (int c = 0; c < int'(i_num_cfg); c++) begin
            push(RSTC, 1, 0, 1, 0, c);
            push(SETC, 0, 0, 0, 0, c);
            push(mns + 1, 0, 1, 0, 0, c);   // data counter reaches N one cycle after N runs
            push(2, 0, 0, 1, 0, c);
            push(1, 0, 0, 1, 1, c);
          end
          mexp = tl.pop_front();
        end
      end
    end
    if (i_cfg_we && !was_busy)
      case (i_cfg_field)
        3'd0: mtbl[i_cfg_idx].ma   = i_cfg_data;
        3'd1: mtbl[i_cfg_idx].mb   = i_cfg_data;
        3'd2: mtbl[i_cfg_idx].bsa  = i_cfg_data;
        3'd3: mtbl[i_cfg_idx].bsb  = i_cfg_data;
        3'd4: mtbl[i_cfg_idx].bca  = i_cfg_data;
        3'd5: mtbl[i_cfg_idx].bcb  = i_cfg_data;
        3'd6: mtbl[i_cfg_idx].fsel = i_cfg_data[0];
        default: ;
      endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_dut or negedge reset);
      if (!reset) model_reset(); else model_step();
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk_dut);
    if (chk_on) begin
      chk("ctrl", {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done},
                  {mexp.rst, mexp.en, mexp.fr, mexp.busy, mexp.done});
      chk("cur_cfg", o_cur_cfg, mexp.cur);
      chk("settings", {o_fselect, o_fmanual_a, o_fmanual_b, o_fbitset_a, o_fbitset_b,
                       o_fbitclr_a, o_fbitclr_b}, mexp.cfg);
      chk("result", o_res_event_ctr, mres[i_res_idx]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(); @(negedge clk_dut); #1; endtask

  task automatic wr(input int idx, input int f, input logic [W-1:0] d);
    i_cfg_we = 1; i_cfg_idx = IW'(idx); i_cfg_field = 3'(f); i_cfg_data = d;
    step();
    i_cfg_we = 0;
  endtask

  task automatic start(input int nc, input int ns);
    i_num_cfg = (IW+1)'(nc); i_num_samples = 32'(ns); i_start = 1;
    step();
    i_start = 0;
  endtask

  task automatic rd(input int idx, input logic [31:0] req, input string nm);
    i_res_idx = IW'(idx); #1;
    chk(nm, o_res_event_ctr, req);
  endtask

  task automatic run_to_done(output int clr, output int stl, output int run,
                             output int bsy, output int curmax);
    int k;
    clr = 0; stl = 0; run = 0; bsy = 0; curmax = 0; k = 0;
    while (!o_done && k < 3000) begin
      if (o_tb_reset && o_fbitset_a == 16'h0001) clr++;
      if (o_busy && !o_tb_reset && !o_tb_enable && !o_tb_freeze) stl++;
      if (o_tb_enable) run++;
      if (o_busy) bsy++;
      if (int'(o_cur_cfg) > curmax) curmax = int'(o_cur_cfg);
      step(); k++;
    end
    chk("done_reached", o_done, 1'b1);
    step();
  endtask

  initial begin
    int clr, stl, run, bsy, cm, k;
    repeat (3) @(negedge clk_dut);
    chk_on = 1;
    #1;
    chk("reset_ctrl", {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done}, 5'b10100);
    reset = 1;
    step();
    chk("idle_tb_reset", o_tb_reset, 1'b0);

    // single config, fault select plus bitset
    wr(0, 6, 16'h0001); wr(0, 2, 16'h0001);
    start(1, 100);
    run_to_done(clr, stl, run, bsy, cm);
    chk("t1_clear_cycles", 32'(clr), 32'd4);
    chk("t1_settle_cycles", 32'(stl), 32'd8);
    chk("t1_run_cycles", 32'(run), 32'd101);
    rd(0, 32'd304, "t1_result0");

    // three configs with distinct bitclr_b
    wr(0, 5, 16'h8000); wr(1, 5, 16'h4000); wr(2, 5, 16'h0001);
    start(3, 5);
    run_to_done(clr, stl, run, bsy, cm);
    chk("t2_busy_cycles", 32'(bsy), 32'd63);
    chk("t2_last_cfg", 32'(cm), 32'd2);
    rd(0, 32'h8013, "t2_result0"); rd(1, 32'h4012, "t2_result1"); rd(2, 32'h0013, "t2_result2");

    // zero samples: one RUN cycle per config
    start(2, 0);
    run_to_done(clr, stl, run, bsy, cm);
    chk("t3_run_cycles", 32'(run), 32'd2);
    chk("t3_busy_cycles", 32'(bsy), 32'd32);
    rd(0, 32'h8004, "t3_result0"); rd(1, 32'h4003, "t3_result1");

    // zero configs: straight to DONE
    start(0, 7);
    chk("t4_done", {o_done, o_busy}, 2'b10);
    step();
    chk("t4_back_idle", {o_done, o_busy}, 2'b00);
    rd(2, 32'h0013, "t4_result2_kept");

    // abort in RUN of cfg1; busy table write dropped
    wr(3, 5, 16'h2000);
    start(4, 10);
    wr(2, 5, 16'h1234);
    k = 0;
    while (!(o_cur_cfg == 3'd1 && o_tb_enable) && k < 500) begin step(); k++; end
    chk("t5_reached_run1", {o_cur_cfg, o_tb_enable}, {3'd1, 1'b1});
    i_abort = 1; step(); i_abort = 0;
    chk("t5_abort_ctrl", {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done}, 5'b00100);
    rd(0, 32'h8022, "t5_result0"); rd(1, 32'h4003, "t5_result1_kept");

    // the dropped write must not have reached cfg2
    start(3, 0);
    run_to_done(clr, stl, run, bsy, cm);
    rd(2, 32'h0004, "t6_result2"); rd(0, 32'h8004, "t6_result0");

    // async reset during SETTLE
    start(3, 0);
    k = 0;
    while (!(o_busy && !o_tb_reset && !o_tb_freeze) && k < 100) begin step(); k++; end
    chk("t7_in_settle", {o_busy, o_tb_reset, o_tb_enable, o_tb_freeze}, 4'b1000);
    i_res_idx = 3'd2;
    #2 reset = 0;
    #1;
    chk("t7_reset_ctrl", {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done}, 5'b10100);
    chk("t7_reset_result", o_res_event_ctr, 32'd0);
    chk("t7_reset_settings", {o_fbitclr_b, o_fselect}, 17'd0);
    step(); step();
    reset = 1;
    step();
    chk("t7_post_idle", {o_tb_reset, o_tb_freeze, o_busy}, 3'b010);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
